// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C byte framer slice.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam logic [I2C_ADDR_W-1:0] GENERAL_CALL_ADDR = 7'h00;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX_DATA,
    RX_ACK,
    TX_DATA,
    TX_ACK,
    IGNORE
  } i2c_state_t;

endpackage

// File: rtl/i2c_edge_detect.sv
// i2c_edge_detect: turns the synchronized SCL level into single-clk rise/fall pulses.
module i2c_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic scl_sync,
  output logic scl_rise,
  output logic scl_fall
);

  logic scl_prev;

  // Remember SCL from the previous clk; the bus idles high, so reset to 1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scl_prev <= 1'b1;
    end else begin
      scl_prev <= scl_sync;
    end
  end

  assign scl_rise = scl_sync & ~scl_prev;
  assign scl_fall = ~scl_sync & scl_prev;

endmodule

// File: rtl/i2c_byte_framer.sv
// i2c_byte_framer: I2C target byte framing (address decode, ACK, RX/TX bytes).
// Optional feature: define I2C_GENERAL_CALL_EN to also accept address byte 8'h00.
module i2c_byte_framer
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] DEVICE_ADDR = 7'h2A
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_sync,
  input  logic       sda_sync,
  input  logic       start_condition,
  input  logic       stop_condition,
  input  logic [7:0] tx_data,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addr_match,
  output logic       rw_bit,
  output logic       tx_load,
  output logic       master_nack,
  output logic       busy
);

`ifdef I2C_GENERAL_CALL_EN
  localparam logic GC_EN = 1'b1;
`else
  localparam logic GC_EN = 1'b0;
`endif

  i2c_state_t state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rw_q, rw_d;
  logic       addr_match_q, addr_match_d;
  logic       rx_valid_q, rx_valid_d;
  logic       master_nack_q, master_nack_d;
  logic       load_tx;
  logic       scl_rise, scl_fall;
  logic [7:0] rx_byte;
  logic       addr_hit;

  i2c_edge_detect u_edge (
    .clk      (clk),
    .reset    (reset),
    .scl_sync (scl_sync),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall)
  );

  // Byte as it will look once the current SDA bit is shifted in (MSB first).
  assign rx_byte  = {shift_q[6:0], sda_sync};
  // General call is the all-zero address with a write bit; 8'h01 never matches it.
  assign addr_hit = (rx_byte[7:1] == DEVICE_ADDR) ||
                    (GC_EN && (rx_byte == {GENERAL_CALL_ADDR, 1'b0}));

  // Next-state and output decode; START beats STOP, and both beat SCL edges.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    sda_oe_d      = sda_oe_q;
    rx_data_d     = rx_data_q;
    rw_d          = rw_q;
    addr_match_d  = 1'b0;
    rx_valid_d    = 1'b0;
    master_nack_d = 1'b0;
    load_tx       = 1'b0;

    if (start_condition) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else if (stop_condition) begin
      state_d   = IDLE;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (addr_hit) begin
                state_d      = ADDR_ACK;
                addr_match_d = 1'b1;
                rw_d         = rx_byte[0];
              end else begin
                state_d = IGNORE;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        ADDR_ACK, RX_ACK: begin
          // First fall pulls SDA for the ACK slot, second fall ends the slot.
          if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              sda_oe_d  = 1'b1;
              bit_cnt_d = 4'd1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              if ((state_q == ADDR_ACK) && rw_q) begin
                state_d = TX_DATA;
                load_tx = 1'b1;
              end else begin
                state_d = RX_DATA;
              end
            end
          end
        end
        RX_DATA: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d  = 4'd0;
              rx_data_d  = rx_byte;
              rx_valid_d = 1'b1;
              state_d    = RX_ACK;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        TX_DATA: begin
          // Count 0 means a byte still has to be fetched after a master ACK.
          if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              load_tx = 1'b1;
            end else if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = TX_ACK;
            end else begin
              sda_oe_d  = ~shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            if (sda_sync) begin
              master_nack_d = 1'b1;
              state_d       = IGNORE;
            end else begin
              state_d = TX_DATA;
            end
          end
        end
        default: begin
        end
      endcase

      // Loading drives bit 7 immediately and parks the rest MSB-aligned.
      if (load_tx) begin
        sda_oe_d  = ~tx_data[7];
        shift_d   = {tx_data[6:0], 1'b0};
        bit_cnt_d = 4'd1;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      bit_cnt_q     <= 4'd0;
      shift_q       <= 8'h00;
      sda_oe_q      <= 1'b0;
      rx_data_q     <= 8'h00;
      rw_q          <= 1'b0;
      addr_match_q  <= 1'b0;
      rx_valid_q    <= 1'b0;
      master_nack_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      sda_oe_q      <= sda_oe_d;
      rx_data_q     <= rx_data_d;
      rw_q          <= rw_d;
      addr_match_q  <= addr_match_d;
      rx_valid_q    <= rx_valid_d;
      master_nack_q <= master_nack_d;
    end
  end

  assign sda_oe      = sda_oe_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign addr_match  = addr_match_q;
  assign rw_bit      = rw_q;
  assign tx_load     = load_tx;
  assign master_nack = master_nack_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_byte_framer.sv
// tb_i2c_byte_framer: directed I2C transfers against a transaction-level model.
// Honours I2C_GENERAL_CALL_EN so the general-call expectation follows the build.
module tb_i2c_byte_framer;

  localparam logic [6:0] DEV = 7'h2A;
`ifdef I2C_GENERAL_CALL_EN
  localparam logic GC_EN = 1'b1;
`else
  localparam logic GC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scl_sync = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       start_condition = 1'b0;
  logic       stop_condition = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       sda_oe, rx_valid, addr_match, rw_bit, tx_load, master_nack, busy;
  logic [7:0] rx_data;

  int checks = 0;
  int failures = 0;

  logic mon_en = 1'b0;
  logic hi_phase = 1'b0;
  logic exp_oe = 1'b0;
  logic exp_busy = 1'b0;

  int obs_am = 0, obs_tl = 0, obs_nack = 0;
  int exp_am = 0, exp_tl = 0, exp_nack = 0;
  logic [7:0] obs_rx[$];
  logic [7:0] exp_rx[$];
  logic       obs_rw[$];
  logic       exp_rw[$];

  // Open-drain bus: the line is low if either master or target pulls it.
  assign sda_line = sda_m & ~sda_oe;

  i2c_byte_framer #(.DEVICE_ADDR(DEV)) dut (
    .clk             (clk),
    .reset           (reset),
    .scl_sync        (scl_sync),
    .sda_sync        (sda_line),
    .start_condition (start_condition),
    .stop_condition  (stop_condition),
    .tx_data         (tx_data),
    .sda_oe          (sda_oe),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .addr_match      (addr_match),
    .rw_bit          (rw_bit),
    .tx_load         (tx_load),
    .master_nack     (master_nack),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Safety net so a broken design can never hang the run.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Address acceptance rule of the target, straight from the addressing scheme.
  function automatic logic model_ack_addr(input logic [7:0] a);
    return (a[7:1] == DEV) || (GC_EN && (a == 8'h00));
  endfunction

  // Per-cycle compare: busy always, sda_oe while SCL is high; pulses are logged.
  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput("busy", 32'(busy), 32'(exp_busy));
      if (hi_phase) checkOutput("sda_oe while scl high", 32'(sda_oe), 32'(exp_oe));
      if (addr_match) begin
        obs_am++;
        obs_rw.push_back(rw_bit);
      end
      if (rx_valid) obs_rx.push_back(rx_data);
      if (tx_load) obs_tl++;
      if (master_nack) obs_nack++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // One SCL period: low phase with data change, then high phase with an expected pull.
  task automatic clock_bit(input logic m, input logic e, output logic line);
    scl_sync = 1'b0;
    hi_phase = 1'b0;
    ticks(2);
    sda_m = m;
    ticks(2);
    exp_oe = e;
    scl_sync = 1'b1;
    hi_phase = 1'b1;
    ticks(3);
    line = sda_line;
  endtask

  task automatic do_start();
    scl_sync = 1'b0;
    hi_phase = 1'b0;
    ticks(2);
    sda_m = 1'b1;
    ticks(2);
    scl_sync = 1'b1;
    ticks(2);
    sda_m = 1'b0;
    start_condition = 1'b1;
    tick();
    start_condition = 1'b0;
    exp_busy = 1'b1;
    ticks(2);
  endtask

  task automatic do_stop();
    scl_sync = 1'b0;
    hi_phase = 1'b0;
    ticks(2);
    sda_m = 1'b0;
    ticks(2);
    scl_sync = 1'b1;
    ticks(2);
    sda_m = 1'b1;
    stop_condition = 1'b1;
    tick();
    stop_condition = 1'b0;
    exp_busy = 1'b0;
    ticks(2);
  endtask

  // Eight data clocks plus the ninth (acknowledge) clock.
  task automatic applyStimulus(input logic [7:0] m_byte, input logic [7:0] exp_drive,
                               input logic exp_ack, input logic m_ack,
                               output logic [7:0] line_byte, output logic line_ack);
    logic l;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(m_byte[i], exp_drive[i], l);
      line_byte[i] = l;
    end
    clock_bit(m_ack, exp_ack, line_ack);
  endtask

  // Compare logged pulses against the model for one scenario, then clear both.
  task automatic finish_test(input string name);
    checkOutput({name, " addr_match count"}, 32'(obs_am), 32'(exp_am));
    checkOutput({name, " rx_valid count"}, 32'(obs_rx.size()), 32'(exp_rx.size()));
    foreach (exp_rx[i])
      checkOutput({name, " rx_data"}, (i < obs_rx.size()) ? 32'(obs_rx[i]) : 32'hDEAD, 32'(exp_rx[i]));
    foreach (exp_rw[i])
      checkOutput({name, " rw_bit"}, (i < obs_rw.size()) ? 32'(obs_rw[i]) : 32'hDEAD, 32'(exp_rw[i]));
    checkOutput({name, " tx_load count"}, 32'(obs_tl), 32'(exp_tl));
    checkOutput({name, " master_nack count"}, 32'(obs_nack), 32'(exp_nack));
    obs_am = 0; obs_tl = 0; obs_nack = 0;
    exp_am = 0; exp_tl = 0; exp_nack = 0;
    obs_rx.delete(); exp_rx.delete();
    obs_rw.delete(); exp_rw.delete();
  endtask

  // Address byte plus one data byte written by the master, then STOP.
  task automatic write_xfer(input string name, input logic [7:0] addr, input logic [7:0] data);
    logic       ack, data_ack, la;
    logic [7:0] lb;
    ack = model_ack_addr(addr);
    data_ack = ack && !addr[0];
    do_start();
    applyStimulus(addr, 8'h00, ack, 1'b1, lb, la);
    checkOutput({name, " addr ack on wire"}, 32'(la), 32'(!ack));
    if (ack) begin
      exp_am++;
      exp_rw.push_back(addr[0]);
    end
    applyStimulus(data, 8'h00, data_ack, 1'b1, lb, la);
    checkOutput({name, " data ack on wire"}, 32'(la), 32'(!data_ack));
    if (data_ack) exp_rx.push_back(data);
    do_stop();
    finish_test(name);
  endtask

  initial begin
    logic [7:0] lb;
    logic [7:0] d;
    logic       la, l;

    // Reset values.
    ticks(3);
    checkOutput("reset sda_oe", 32'(sda_oe), 32'h0);
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset rx_data", 32'(rx_data), 32'h00);
    checkOutput("reset rw_bit", 32'(rw_bit), 32'h0);
    checkOutput("reset addr_match", 32'(addr_match), 32'h0);
    checkOutput("reset rx_valid", 32'(rx_valid), 32'h0);
    checkOutput("reset tx_load", 32'(tx_load), 32'h0);
    checkOutput("reset master_nack", 32'(master_nack), 32'h0);
    reset = 1'b1;
    mon_en = 1'b1;
    ticks(2);

    // Plain writes to our address.
    write_xfer("write_54_a5", 8'h54, 8'hA5);
    checkOutput("rx_data after write", 32'(rx_data), 32'hA5);
    checkOutput("busy after stop", 32'(busy), 32'h0);
    write_xfer("write_54_81", 8'h54, 8'h81);

    // Foreign address is ignored and leaves rx_data alone.
    write_xfer("addr_2b", 8'h56, 8'hFF);
    checkOutput("rx_data after foreign addr", 32'(rx_data), 32'h81);

    // Read of two bytes: master ACKs the first, NACKs the second.
    tx_data = 8'h3C;
    do_start();
    applyStimulus(8'h55, 8'h00, model_ack_addr(8'h55), 1'b1, lb, la);
    checkOutput("read addr ack on wire", 32'(la), 32'h0);
    checkOutput("read rw_bit", 32'(rw_bit), 32'h1);
    exp_am++;
    exp_rw.push_back(1'b1);
    applyStimulus(8'hFF, ~8'h3C, 1'b0, 1'b0, lb, la);
    exp_tl++;
    checkOutput("read byte0 on wire", 32'(lb), 32'h3C);
    tx_data = 8'h96;
    applyStimulus(8'hFF, ~8'h96, 1'b0, 1'b1, lb, la);
    exp_tl++;
    exp_nack++;
    checkOutput("read byte1 on wire", 32'(lb), 32'h96);
    do_stop();
    finish_test("read_55");

    // Repeated START after four data bits drops the partial byte.
    do_start();
    applyStimulus(8'h54, 8'h00, 1'b1, 1'b1, lb, la);
    exp_am++;
    exp_rw.push_back(1'b0);
    for (int i = 0; i < 4; i++) clock_bit(1'b1, 1'b0, l);
    write_xfer("restart_then_write", 8'h54, 8'h11);

    // Reset while the target is holding the data ACK.
    d = 8'h5A;
    do_start();
    applyStimulus(8'h54, 8'h00, 1'b1, 1'b1, lb, la);
    exp_am++;
    exp_rw.push_back(1'b0);
    for (int i = 7; i >= 0; i--) clock_bit(d[i], 1'b0, l);
    exp_rx.push_back(8'h5A);
    scl_sync = 1'b0;
    hi_phase = 1'b0;
    ticks(4);
    scl_sync = 1'b1;
    ticks(2);
    checkOutput("ack held before reset", 32'(sda_oe), 32'h1);
    reset = 1'b0;
    tick();
    exp_busy = 1'b0;
    checkOutput("sda_oe after mid reset", 32'(sda_oe), 32'h0);
    checkOutput("busy after mid reset", 32'(busy), 32'h0);
    checkOutput("rx_data after mid reset", 32'(rx_data), 32'h00);
    reset = 1'b1;
    sda_m = 1'b1;
    ticks(2);
    finish_test("reset_mid_ack");

    // General call address and its read variant.
    write_xfer("general_call_00", 8'h00, 8'h77);
    write_xfer("addr_01", 8'h01, 8'h66);

    // START and STOP in the same clk: START wins.
    start_condition = 1'b1;
    stop_condition = 1'b1;
    tick();
    start_condition = 1'b0;
    stop_condition = 1'b0;
    exp_busy = 1'b1;
    checkOutput("start beats stop", 32'(busy), 32'h1);
    do_stop();
    finish_test("start_stop_same_clk");

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_byte_framer.md
I2C_BYTE_FRAMER -- requirements
Module: i2c_byte_framer

Interface
REQ-001 SHALL have parameter DEVICE_ADDR, default 7'h2A, 7-bit target address.
REQ-002 SHALL have port clk  input  1  system clock; all logic on posedge clk.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port scl_sync  input  1  SCL, already synchronized to clk.
REQ-005 SHALL have port sda_sync  input  1  SDA, already synchronized to clk.
REQ-006 SHALL have port start_condition  input  1  one-cycle pulse, START or repeated START on the wire.
REQ-007 SHALL have port stop_condition  input  1  one-cycle pulse, STOP on the wire.
REQ-008 SHALL have port tx_data  input  8  byte to return on a read transfer.
REQ-009 SHALL have port sda_oe  output  1  1 = pull SDA low (ACK or data 0).
REQ-010 SHALL have port rx_data  output  8  last received data byte.
REQ-011 SHALL have port rx_valid  output  1  one-cycle pulse, rx_data updated.
REQ-012 SHALL have port addr_match  output  1  one-cycle pulse, address byte matched.
REQ-013 SHALL have port rw_bit  output  1  R/W bit of last matched address; 1 = read.
REQ-014 SHALL have port tx_load  output  1  one-cycle pulse, tx_data captured into shift register.
REQ-015 SHALL have port master_nack  output  1  one-cycle pulse, master NACKed a read byte.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL detect SCL rise/fall by comparing scl_sync with its value one clk earlier.
REQ-018 SHALL sample SDA only on the clk of an SCL rising edge; SHALL change sda_oe only on the clk of an SCL falling edge, except at START/STOP/reset.
REQ-019 SHALL implement states IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, IGNORE.
REQ-020 SHALL shift bits MSB first with a 4-bit counter 0..8; counter clears at every byte boundary.
REQ-021 ADDR: after 8th rising edge, match if byte[7:1]==DEVICE_ADDR -> ADDR_ACK, pulse addr_match next clk, latch rw_bit=byte[0]; else -> IGNORE, no pulses.
REQ-022 ADDR_ACK: sda_oe=1 from next SCL fall to the following SCL fall; then RX_DATA if rw_bit=0, TX_DATA if rw_bit=1.
REQ-023 RX_DATA: after 8th rising edge, rx_data updated and rx_valid pulsed the next clk; -> RX_ACK, ACK driven exactly as REQ-022; then back to RX_DATA.
REQ-024 TX_DATA: at the SCL fall ending ADDR_ACK or TX_ACK, capture tx_data and pulse tx_load that clk; sda_oe = ~shift[7] at each SCL fall for 8 bits; release sda_oe at the fall after bit 0 -> TX_ACK.
REQ-025 TX_ACK: sample SDA on 9th rising edge; 0 -> TX_DATA (next byte); 1 -> pulse master_nack, -> IGNORE.
REQ-026 IGNORE: sda_oe=0, no pulses; leave only on start_condition or stop_condition.
REQ-027 start_condition in any state SHALL -> ADDR, clear counter, sda_oe=0 same clk; priority over SCL edges and stop_condition when simultaneous.
REQ-028 stop_condition in any state SHALL -> IDLE, sda_oe=0; a partial byte SHALL be discarded with no rx_valid.
REQ-029 IDLE SHALL ignore SCL edges.

Reset
REQ-030 On clk with reset=0: state IDLE, counter 0, sda_oe 0, rx_data 8'h00, rw_bit 0, all pulses 0, busy 0; mid-transfer reset SHALL abort identically.

Configuration
REQ-031 With I2C_GENERAL_CALL_EN defined, address byte 8'h00 SHALL also match (ACKed, addr_match pulsed, rw_bit=0); an address byte 8'h01 SHALL -> IGNORE.
REQ-032 Without I2C_GENERAL_CALL_EN, only DEVICE_ADDR SHALL match.

Structure
REQ-033 Package i2c_pkg SHALL hold the state enum, I2C_ADDR_W=7, GENERAL_CALL_ADDR=7'h00.
REQ-034 Sub-module i2c_edge_detect SHALL provide scl rise/fall pulses; all else in i2c_byte_framer.

Verification
REQ-035 Write 0x54 then 0xA5, STOP -> addr_match, ACK on 9th clocks, rx_valid with rx_data=8'hA5, busy low after STOP.
REQ-036 Address 0x56 (addr 7'h2B) -> no ACK, IGNORE, no pulses until STOP.
REQ-037 Read 0x55, tx_data=8'h3C, master ACK then NACK -> tx_load twice, SDA bits 00111100, master_nack pulse.
REQ-038 START after 4 data bits of a write -> ADDR, no rx_valid, next address decoded correctly.
REQ-039 Reset=0 mid-RX_ACK with sda_oe=1 -> sda_oe 0, IDLE on next clk.
REQ-040 Address 0x00 with/without I2C_GENERAL_CALL_EN -> ACK+addr_match / IGNORE.
